// File: rtl/div_unit.sv
// div_unit: RV32M integer divider (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per cycle over 32 cycles. Division
// by zero and signed overflow bypass the iteration and finish in one cycle.
// Signs are stripped on entry and restored on the last step.
`timescale 1ns/1ps

// add_sub: 32-bit adder/subtractor. With i_op=1 it computes i_a - i_b, and
// o_cout=1 means no borrow, i.e. i_a >= i_b as unsigned values.
module add_sub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_op,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [31:0] w_b_eff;
  logic [32:0] w_full;

  assign w_b_eff = i_op ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, i_op};
  assign o_sum   = w_full[31:0];
  assign o_cout  = w_full[32];
endmodule

module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [4:0]  r_count;
  logic [1:0]  r_op;
  logic        r_a_neg;
  logic        r_b_neg;
  logic [31:0] r_result;

  // operand classification at acceptance time
  logic        w_signed;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_special_result;

  // iteration step
  logic [31:0] w_s;
  logic [31:0] w_t;
  logic        w_cout;
  logic        w_msb;
  logic        w_take;
  logic [31:0] w_rem_step;
  logic [31:0] w_quo_step;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_calc_result;
  logic        w_last_step;

  // op[0]=0 selects the signed variants (DIV/REM)
  assign w_signed  = ~op[0];
  assign w_b_zero  = (b == 32'h0000_0000);
  assign w_ovf     = w_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_special = w_b_zero || w_ovf;

  // Magnitudes; -0x80000000 wraps to itself, which is the right unsigned magnitude
  assign w_abs_a = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_abs_b = (w_signed && b[31]) ? (32'd0 - b) : b;

  // Results of the bypass cases, selected by quotient/remainder
  always_comb begin
    w_special_result = 32'h0000_0000;
    if (w_b_zero) begin
      if (op[1]) begin
        w_special_result = a;
      end else begin
        w_special_result = 32'hFFFF_FFFF;
      end
    end else begin
      if (op[1]) begin
        w_special_result = 32'h0000_0000;
      end else begin
        w_special_result = 32'h8000_0000;
      end
    end
  end

  // Shift the next dividend bit into the partial remainder and trial-subtract
  assign w_s   = {r_rem[30:0], r_quo[31]};
  assign w_msb = r_rem[31];

  add_sub u_add_sub (
    .i_a    (w_s),
    .i_b    (r_div),
    .i_op   (1'b1),
    .o_sum  (w_t),
    .o_cout (w_cout)
  );

  // A set msb means the shifted remainder is 33 bits wide and always >= divisor
  assign w_take      = w_msb | w_cout;
  assign w_rem_step  = w_take ? w_t : w_s;
  assign w_quo_step  = {r_quo[30:0], w_take};
  assign w_last_step = (r_count == 5'd31);

  // Restore signs on the final step: quotient by sign difference, remainder by dividend
  always_comb begin
    w_quo_fix = w_quo_step;
    w_rem_fix = w_rem_step;
    if (!r_op[0]) begin
      if (r_a_neg ^ r_b_neg) begin
        w_quo_fix = 32'd0 - w_quo_step;
      end else begin
        w_quo_fix = w_quo_step;
      end
      if (r_a_neg) begin
        w_rem_fix = 32'd0 - w_rem_step;
      end else begin
        w_rem_fix = w_rem_step;
      end
    end else begin
      w_quo_fix = w_quo_step;
      w_rem_fix = w_rem_step;
    end
  end

  assign w_calc_result = r_op[1] ? w_rem_fix : w_quo_fix;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_special) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_CALC;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (w_last_step) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CALC;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Datapath: latch operands on acceptance, iterate in CALC, capture result on exit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo    <= 32'h0000_0000;
      r_rem    <= 32'h0000_0000;
      r_div    <= 32'h0000_0000;
      r_count  <= 5'd0;
      r_op     <= 2'b00;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_result <= 32'h0000_0000;
    end else if (!flush) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a_neg <= a[31];
            r_b_neg <= b[31];
            if (w_special) begin
              r_result <= w_special_result;
            end else begin
              r_quo   <= w_abs_a;
              r_rem   <= 32'h0000_0000;
              r_div   <= w_abs_b;
              r_count <= 5'd0;
            end
          end
        end
        ST_CALC: begin
          r_quo   <= w_quo_step;
          r_rem   <= w_rem_step;
          r_count <= r_count + 5'd1;
          if (w_last_step) begin
            r_result <= w_calc_result;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign ready  = (r_state == ST_IDLE);
  assign busy   = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks;
  int n_errors;
  int cyc;
  logic [31:0] last_result;

  div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics in plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] f_op, input logic [31:0] f_a,
                                        input logic [31:0] f_b);
    int sa;
    int sb;
    sa = f_a;
    sb = f_b;
    if (f_b == 32'd0) return f_op[1] ? f_a : 32'hFFFF_FFFF;
    if (!f_op[0]) begin
      if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF)
        return f_op[1] ? 32'd0 : 32'h8000_0000;
      return f_op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f_op[1] ? (f_a % f_b) : (f_a / f_b);
  endfunction

  function automatic int latency(input logic [1:0] f_op, input logic [31:0] f_a,
                                 input logic [31:0] f_b);
    if (f_b == 32'd0) return 1;
    if (!f_op[0] && f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present an operation for one edge; afterwards we are in cycle 1
  task automatic launch(input logic [1:0] l_op, input logic [31:0] l_a, input logic [31:0] l_b);
    op = l_op;
    a = l_a;
    b = l_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
    cyc = 1;
  endtask

  // Wait (bounded) for done, check latency/result, then the single-cycle pulse
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    while (done !== 1'b1 && cyc < 60) tick();
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_hold"}, result, exp_res);
    last_result = exp_res;
  endtask

  task automatic run_op(input string tag, input logic [1:0] r_op, input logic [31:0] r_a,
                        input logic [31:0] r_b);
    logic [31:0] exp_res;
    int exp_lat;
    exp_res = model(r_op, r_a, r_b);
    exp_lat = latency(r_op, r_a, r_b);
    launch(r_op, r_a, r_b);
    wait_done(tag, exp_lat, exp_res);
  endtask

  // Count done pulses over a window where none may appear
  task automatic expect_no_done(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int sel;

    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    last_result = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    tick();

    // Directed operations
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    check("divu_100_7_const", model(2'b01, 32'd100, 32'd7), 32'd14);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_b0", 2'b01, 32'h0000_1234, 32'd0);
    run_op("rem_b0", 2'b10, 32'h0000_1234, 32'd0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
    run_op("remu_msb", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("divu_ovf_operands", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_neg", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    run_op("rem_neg_div", 2'b10, 32'd100, 32'hFFFF_FFF9);

    // Start with new operands on cycle 5 of CALC must be ignored
    launch(2'b01, 32'd1000, 32'd3);
    while (cyc < 5) tick();
    op = 2'b01;
    a = 32'd77;
    b = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", 33, 32'd333);

    // Flush on cycle 10: back to IDLE, no done, result untouched
    launch(2'b01, 32'd5000, 32'd9);
    while (cyc < 10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result", result, last_result);
    expect_no_done("flush_no_done", 40);

    // Flush together with start in IDLE: not accepted
    op = 2'b01;
    a = 32'd50;
    b = 32'd0;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_ready", {31'd0, ready}, 32'd1);
    expect_no_done("flush_start_no_done", 5);

    // Reset on cycle 20: abandoned, result cleared, no done
    launch(2'b00, 32'hFFFF_0000, 32'd13);
    while (cyc < 20) tick();
    reset = 1'b1;
    start = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_result", result, 32'd0);
    expect_no_done("reset_no_done", 40);
    run_op("after_reset", 2'b11, 32'd12345, 32'd100);

    // Back-to-back: wait_done leaves us in the cycle after done (IDLE)
    run_op("b2b_first", 2'b00, 32'd81, 32'hFFFF_FFFD);
    run_op("b2b_second", 2'b10, 32'd82, 32'd5);
    run_op("b2b_special", 2'b01, 32'd9, 32'd0);
    run_op("b2b_after_special", 2'b01, 32'd9, 32'd4);

    // Randomized operations, biased toward the corner cases
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      r_op = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = $urandom;
      if (sel == 0) r_b = 32'd0;
      if (sel == 1) begin
        r_a = 32'h8000_0000;
        r_b = 32'hFFFF_FFFF;
      end
      if (sel == 2) r_b = 32'($urandom_range(1, 20));
      if (sel == 3) r_b = 32'd0 - 32'($urandom_range(1, 20));
      run_op("random", r_op, r_a, r_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports are listed clock and reset first:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  request a new operation; accepted only when ready=1.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-006 a  input  32  dividend (rs1).
REQ-007 b  input  32  divisor (rs2).
REQ-008 flush  input  1  abort the in-flight operation (pipeline flush).
REQ-009 ready  output  1  high when in IDLE.
REQ-010 busy  output  1  high in CALC or DONE; drives the decode/execute stall.
REQ-011 done  output  1  one-cycle pulse; result is valid while done=1.
REQ-012 result  output  32  quotient or remainder; holds its value until the next done.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE, with IDLE as the reset state.
REQ-014 Acceptance SHALL be start=1 and state=IDLE at a rising edge; a, b and op are latched on that edge, and start in any other state is ignored.
REQ-015 Special case, b=0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be a; IDLE goes directly to DONE.
REQ-016 Special case, signed op with a=0x80000000 and b=0xFFFFFFFF: quotient SHALL be 0x80000000 and remainder SHALL be 0; IDLE goes directly to DONE.
REQ-017 Otherwise IDLE SHALL go to CALC, loading Q=|a|, R=0, D=|b| and count=0; absolute values are taken only for DIV/REM.
REQ-018 CALC SHALL perform one restoring step per cycle for exactly 32 cycles, then enter DONE.
REQ-019 Each step: S={R[30:0],Q[31]}; trial difference T=S-D from an add_sub instance with op=1; msb=R[31].
REQ-020 If msb=1 or cout=1, then R=T and the new Q LSB=1; else R=S and the new Q LSB=0; Q shifts left by one.
REQ-021 The sign fix-up SHALL be applied on the CALC-to-DONE transition.
REQ-022 Sign fix-up: for DIV, the quotient is negated when a[31]^b[31]; for REM, the remainder is negated when a[31]; unsigned ops are not modified.
REQ-023 result SHALL be the quotient for op[1]=0 and the remainder for op[1]=1, registered on entry to DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 A start on the cycle after DONE SHALL be accepted, giving back-to-back operations with no idle cycle beyond IDLE.
REQ-026 Latency, normal case: done SHALL be high in the 33rd cycle after the acceptance edge.
REQ-027 Latency, special cases: done SHALL be high in the cycle immediately after the acceptance edge.
REQ-028 flush=1 SHALL force IDLE on the next edge with no done pulse; result is unchanged; flush has priority over start and over DONE.
REQ-029 flush=1 together with start=1 in IDLE: the operation SHALL NOT be accepted.
REQ-030 All arithmetic SHALL be 32-bit modulo 2^32; negation is two's complement (-0x80000000 = 0x80000000).

Reset
REQ-031 reset=1 SHALL force IDLE and set done=0, busy=0, ready=1, result=0x00000000 and count=0; Q, R and D are cleared.
REQ-032 reset SHALL take priority over flush and start.
REQ-033 reset asserted mid-CALC SHALL abandon the operation with no done pulse.
REQ-034 The first start after reset is released SHALL be accepted normally.

Verification
REQ-035 DIVU a=100, b=7 -> result=14 with done in the 33rd cycle; repeated with REMU -> result=2.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3); REM with the same operands -> result=0xFFFFFFFF (-1).
REQ-037 Special cases:
- DIVU a=0x1234, b=0 -> result=0xFFFFFFFF, done after 1 cycle.
- REM a=0x1234, b=0 -> result=0x1234.
- DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000.
- REM with the same operands -> result=0.
REQ-038 DIVU a=0xFFFFFFFF, b=1 -> result=0xFFFFFFFF; REMU a=0xFFFFFFFF, b=0x80000001 -> result=0x7FFFFFFE (exercises msb=1 path).
REQ-039 Busy start: start with new operands on cycle 5 of CALC is ignored and the original result is produced.
REQ-040 Flush: flush on cycle 10 of CALC -> IDLE next cycle, no done, result unchanged.
REQ-041 Reset: reset on cycle 20 of CALC -> IDLE, result=0, no done.
REQ-042 Back-to-back: start asserted in the cycle after done is accepted and completes correctly.
